// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file: addresses, Zicsr op encoding,
// status/interrupt bit positions and trap cause codes.
package csr_pkg;

  localparam int unsigned XLEN = 32;

  // Machine information
  localparam logic [11:0] CSR_MVENDORID     = 12'hF11;
  localparam logic [11:0] CSR_MARCHID       = 12'hF12;
  localparam logic [11:0] CSR_MIMPID        = 12'hF13;
  localparam logic [11:0] CSR_MHARTID       = 12'hF14;

  // Machine trap setup / handling
  localparam logic [11:0] CSR_MSTATUS       = 12'h300;
  localparam logic [11:0] CSR_MISA          = 12'h301;
  localparam logic [11:0] CSR_MIE           = 12'h304;
  localparam logic [11:0] CSR_MTVEC         = 12'h305;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
  localparam logic [11:0] CSR_MEPC          = 12'h341;
  localparam logic [11:0] CSR_MCAUSE        = 12'h342;
  localparam logic [11:0] CSR_MTVAL         = 12'h343;
  localparam logic [11:0] CSR_MIP           = 12'h344;

  // Counter banks: 0xB00/0xB80 machine lo/hi, 0xC00/0xC80 user shadows lo/hi
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_CYCLE         = 12'hC00;
  localparam logic [11:0] CSR_TIME          = 12'hC01;
  localparam logic [11:0] CSR_INSTRET       = 12'hC02;

  localparam int unsigned CNT_IDX_CYCLE    = 0;
  localparam int unsigned CNT_IDX_TIME     = 1;
  localparam int unsigned CNT_IDX_INSTRET  = 2;
  localparam int unsigned CNT_IDX_HPM_BASE = 3;

  typedef enum logic [2:0] {
    CSR_OP_RSV0 = 3'b000,
    CSR_OP_RW   = 3'b001,
    CSR_OP_RS   = 3'b010,
    CSR_OP_RC   = 3'b011,
    CSR_OP_RSV4 = 3'b100,
    CSR_OP_RWI  = 3'b101,
    CSR_OP_RSI  = 3'b110,
    CSR_OP_RCI  = 3'b111
  } csr_op_e;

  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;
  localparam int unsigned MIP_MSIP_BIT     = 3;
  localparam int unsigned MIP_MTIP_BIT     = 7;
  localparam int unsigned MIP_MEIP_BIT     = 11;

  localparam logic [31:0] MIE_MASK = 32'h0000_0888;

  localparam logic [31:0] CAUSE_IRQ_SOFT    = 32'h8000_0003;
  localparam logic [31:0] CAUSE_IRQ_TIMER   = 32'h8000_0007;
  localparam logic [31:0] CAUSE_IRQ_EXT     = 32'h8000_000B;
  localparam logic [31:0] CAUSE_ILLEGAL_INS = 32'h0000_0002;
  localparam logic [31:0] CAUSE_ECALL_M     = 32'h0000_000B;

  // Counter banks share a layout: bits [4:0] pick the counter, bit 7 picks the half.
  function automatic logic is_counter_addr(input logic [11:0] addr);
    return ((addr[11:8] == 4'hB) || (addr[11:8] == 4'hC)) && (addr[6:5] == 2'b00);
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit event counter with inhibit and independently writable 32-bit halves.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        inhibit,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] value
);

  logic [63:0] cnt_q;
  logic [63:0] cnt_d;

  // A half write overrides the increment; the other half keeps its old value.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && !inhibit) cnt_d = cnt_q + 64'd1;
    if (wr_lo)           cnt_d = {cnt_q[63:32], wdata};
    if (wr_hi)           cnt_d = {wdata, cnt_q[31:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign value = cnt_q;

endmodule

// File: rtl/csr_trap_file.sv
// Machine-mode CSR file: Zicsr execution, trap entry / MRET sequencing,
// interrupt-pending generation and the cycle/instret/HPM counters.
module csr_trap_file
  import csr_pkg::*;
#(
  parameter int unsigned NUM_HPM     = 3,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] MISA_VAL    = 32'h4000_1127,
  parameter logic [31:0] HART_ID     = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               csr_req,
  input  logic [2:0]         csr_func3,
  input  logic [11:0]        csr_addr,
  input  logic [31:0]        csr_rs1_data,
  input  logic [4:0]         csr_imm,
  output logic               csr_done,
  output logic [31:0]        csr_rdata,
  output logic               csr_illegal,
  input  logic               instr_retired,
  input  logic [NUM_HPM-1:0] hpm_event,
  input  logic               trap_valid,
  input  logic [31:0]        trap_cause,
  input  logic [31:0]        trap_pc,
  input  logic [31:0]        trap_tval,
  input  logic               mret,
  output logic [31:0]        trap_vector,
  output logic [31:0]        mret_pc,
  input  logic               irq_ext,
  input  logic               irq_timer,
  input  logic               irq_soft,
  output logic               irq_pending
);

  localparam logic [31:0] INH_MASK =
    32'h0000_0005 | 32'(((64'd1 << NUM_HPM) - 64'd1) << 3);

  logic        mie_bit_q, mpie_q;
  logic [31:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q, mcountinhibit_q;

  logic [63:0] mcycle_val, minstret_val, cnt_sel;
  logic [63:0] hpm_val [NUM_HPM];

  logic [31:0] mip_view, mstatus_view, rd_val, op_val, wdata, tvec_base;
  logic        addr_ok, wr_attempt, func_ok, illegal, do_write, cnt_wr;
  logic [4:0]  cnt_idx;
  csr_op_e     op;

  assign op      = csr_op_e'(csr_func3);
  assign cnt_idx = csr_addr[4:0];

  always_comb begin
    mip_view               = '0;
    mip_view[MIP_MEIP_BIT] = irq_ext;
    mip_view[MIP_MTIP_BIT] = irq_timer;
    mip_view[MIP_MSIP_BIT] = irq_soft;
  end

  // MPP is hardwired to machine mode.
  always_comb begin
    mstatus_view                   = '0;
    mstatus_view[12:11]            = 2'b11;
    mstatus_view[MSTATUS_MPIE_BIT] = mpie_q;
    mstatus_view[MSTATUS_MIE_BIT]  = mie_bit_q;
  end

  // Counter selection; absent HPM slots fall through as zero.
  always_comb begin
    cnt_sel = '0;
    if (cnt_idx == 5'(CNT_IDX_CYCLE))   cnt_sel = mcycle_val;
    if (cnt_idx == 5'(CNT_IDX_INSTRET)) cnt_sel = minstret_val;
    for (int k = 0; k < int'(NUM_HPM); k++) begin
      if (cnt_idx == 5'(CNT_IDX_HPM_BASE + 32'(k))) cnt_sel = hpm_val[k];
    end
  end

  // Read mux and address decode
  always_comb begin
    rd_val  = '0;
    addr_ok = 1'b1;
    case (csr_addr)
      CSR_MSTATUS:       rd_val = mstatus_view;
      CSR_MISA:          rd_val = MISA_VAL;
      CSR_MIE:           rd_val = mie_q;
      CSR_MTVEC:         rd_val = mtvec_q;
      CSR_MCOUNTINHIBIT: rd_val = mcountinhibit_q;
      CSR_MSCRATCH:      rd_val = mscratch_q;
      CSR_MEPC:          rd_val = mepc_q;
      CSR_MCAUSE:        rd_val = mcause_q;
      CSR_MTVAL:         rd_val = mtval_q;
      CSR_MIP:           rd_val = mip_view;
      CSR_MVENDORID,
      CSR_MARCHID,
      CSR_MIMPID:        rd_val = '0;
      CSR_MHARTID:       rd_val = HART_ID;
      default: begin
        if (is_counter_addr(csr_addr)) begin
          if (cnt_idx == 5'(CNT_IDX_TIME)) begin
            // time/timeh exist only as read-only zeros in the user bank
            addr_ok = (csr_addr[11:8] == 4'hC);
          end else begin
            rd_val = csr_addr[7] ? cnt_sel[63:32] : cnt_sel[31:0];
          end
        end else begin
          addr_ok = 1'b0;
        end
      end
    endcase
  end

  assign op_val = csr_func3[2] ? 32'(csr_imm) : csr_rs1_data;

  always_comb begin
    case (op)
      CSR_OP_RW, CSR_OP_RWI: wdata = op_val;
      CSR_OP_RS, CSR_OP_RSI: wdata = rd_val | op_val;
      CSR_OP_RC, CSR_OP_RCI: wdata = rd_val & ~op_val;
      default:               wdata = rd_val;
    endcase
  end

  // Set/clear with a zero source is a pure read.
  assign wr_attempt = (op == CSR_OP_RW) || (op == CSR_OP_RWI) || (csr_imm != 5'd0);
  assign func_ok    = (op != CSR_OP_RSV0) && (op != CSR_OP_RSV4);
  assign illegal    = !func_ok || !addr_ok || (wr_attempt && (csr_addr[11:10] == 2'b11));
  assign do_write   = csr_req && !illegal && wr_attempt && !trap_valid && !mret;
  assign cnt_wr     = do_write && (csr_addr[11:8] == 4'hB) && is_counter_addr(csr_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csr_done    <= 1'b0;
      csr_illegal <= 1'b0;
      csr_rdata   <= '0;
    end else begin
      csr_done    <= csr_req;
      csr_illegal <= csr_req && illegal;
      csr_rdata   <= (csr_req && !illegal) ? rd_val : '0;
    end
  end

  // Architectural state: trap beats MRET beats CSR write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_bit_q       <= 1'b0;
      mpie_q          <= 1'b0;
      mie_q           <= '0;
      mtvec_q         <= MTVEC_RESET;
      mscratch_q      <= '0;
      mepc_q          <= '0;
      mcause_q        <= '0;
      mtval_q         <= '0;
      mcountinhibit_q <= '0;
    end else if (trap_valid) begin
      mepc_q    <= {trap_pc[31:2], 2'b00};
      mcause_q  <= trap_cause;
      mtval_q   <= trap_tval;
      mpie_q    <= mie_bit_q;
      mie_bit_q <= 1'b0;
    end else if (mret) begin
      mie_bit_q <= mpie_q;
      mpie_q    <= 1'b1;
    end else if (do_write) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mie_bit_q <= wdata[MSTATUS_MIE_BIT];
          mpie_q    <= wdata[MSTATUS_MPIE_BIT];
        end
        CSR_MIE:           mie_q           <= wdata & MIE_MASK;
        CSR_MTVEC:         mtvec_q         <= {wdata[31:2], wdata[1] ? 2'b00 : wdata[1:0]};
        CSR_MCOUNTINHIBIT: mcountinhibit_q <= wdata & INH_MASK;
        CSR_MSCRATCH:      mscratch_q      <= wdata;
        CSR_MEPC:          mepc_q          <= {wdata[31:2], 2'b00};
        CSR_MCAUSE:        mcause_q        <= wdata;
        CSR_MTVAL:         mtval_q         <= wdata;
        default:           ;
      endcase
    end
  end

  csr_counter64 u_mcycle (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (1'b1),
    .inhibit (mcountinhibit_q[CNT_IDX_CYCLE]),
    .wr_lo   (cnt_wr && !csr_addr[7] && (cnt_idx == 5'(CNT_IDX_CYCLE))),
    .wr_hi   (cnt_wr &&  csr_addr[7] && (cnt_idx == 5'(CNT_IDX_CYCLE))),
    .wdata   (wdata),
    .value   (mcycle_val)
  );

  csr_counter64 u_minstret (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (instr_retired),
    .inhibit (mcountinhibit_q[CNT_IDX_INSTRET]),
    .wr_lo   (cnt_wr && !csr_addr[7] && (cnt_idx == 5'(CNT_IDX_INSTRET))),
    .wr_hi   (cnt_wr &&  csr_addr[7] && (cnt_idx == 5'(CNT_IDX_INSTRET))),
    .wdata   (wdata),
    .value   (minstret_val)
  );

  for (genvar k = 0; k < int'(NUM_HPM); k++) begin : g_hpm
    csr_counter64 u_hpm (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc     (hpm_event[k]),
      .inhibit (mcountinhibit_q[CNT_IDX_HPM_BASE + k]),
      .wr_lo   (cnt_wr && !csr_addr[7] && (cnt_idx == 5'(CNT_IDX_HPM_BASE + k))),
      .wr_hi   (cnt_wr &&  csr_addr[7] && (cnt_idx == 5'(CNT_IDX_HPM_BASE + k))),
      .wdata   (wdata),
      .value   (hpm_val[k])
    );
  end

  assign tvec_base   = {mtvec_q[31:2], 2'b00};
  assign trap_vector = ((mtvec_q[1:0] == 2'b01) && trap_cause[31])
                       ? tvec_base + {25'd0, trap_cause[4:0], 2'b00}
                       : tvec_base;
  assign mret_pc     = mepc_q;
  assign irq_pending = mie_bit_q && |(mip_view & mie_q);

endmodule

// File: tb/tb_csr_trap_file.sv
// Bench for csr_trap_file: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a behavioural model of the CSR file.
module tb_csr_trap_file;

  localparam int N_HPM = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic csr_req;
  logic [2:0] csr_func3;
  logic [11:0] csr_addr;
  logic [31:0] csr_rs1_data;
  logic [4:0] csr_imm;
  logic csr_done;
  logic [31:0] csr_rdata;
  logic csr_illegal;
  logic instr_retired;
  logic [N_HPM-1:0] hpm_event;
  logic trap_valid;
  logic [31:0] trap_cause, trap_pc, trap_tval;
  logic mret;
  logic [31:0] trap_vector, mret_pc;
  logic irq_ext, irq_timer, irq_soft;
  logic irq_pending;

  int checks = 0;
  int errors = 0;

  csr_trap_file #(.NUM_HPM(N_HPM)) dut (
    .clk(clk), .rst_n(rst_n),
    .csr_req(csr_req), .csr_func3(csr_func3), .csr_addr(csr_addr),
    .csr_rs1_data(csr_rs1_data), .csr_imm(csr_imm),
    .csr_done(csr_done), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .instr_retired(instr_retired), .hpm_event(hpm_event),
    .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_tval(trap_tval),
    .mret(mret), .trap_vector(trap_vector), .mret_pc(mret_pc),
    .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_soft(irq_soft),
    .irq_pending(irq_pending)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  bit m_mie, m_mpie;
  logic [31:0] m_mie_r, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_inh;
  longint unsigned cnt [32];
  bit skip [32];
  bit exp_done, exp_ill;
  logic [31:0] exp_rdata;
  logic last_done, last_ill;
  logic [31:0] last_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_mie = 0; m_mpie = 0;
    m_mie_r = 0; m_mtvec = 0; m_mscratch = 0; m_mepc = 0;
    m_mcause = 0; m_mtval = 0; m_inh = 0;
    foreach (cnt[i]) cnt[i] = 0;
  endfunction

  function automatic void m_read(input logic [11:0] a, output logic [31:0] v, output bit ok);
    int idx;
    v = 32'h0; ok = 1'b1;
    idx = int'(a[4:0]);
    if ((a[11:8] == 4'hB || a[11:8] == 4'hC) && a[6:5] == 2'b00) begin
      if (idx == 1) ok = (a[11:8] == 4'hC);
      else if (idx < 3 + N_HPM) v = a[7] ? 32'(cnt[idx] >> 32) : 32'(cnt[idx]);
    end else begin
      case (a)
        12'h300: v = 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
        12'h301: v = 32'h4000_1127;
        12'h304: v = m_mie_r;
        12'h305: v = m_mtvec;
        12'h320: v = m_inh;
        12'h340: v = m_mscratch;
        12'h341: v = m_mepc;
        12'h342: v = m_mcause;
        12'h343: v = m_mtval;
        12'h344: v = (32'(irq_ext) << 11) | (32'(irq_timer) << 7) | (32'(irq_soft) << 3);
        12'hF11, 12'hF12, 12'hF13, 12'hF14: v = 32'h0;
        default: ok = 1'b0;
      endcase
    end
  endfunction

  function automatic void m_write(input logic [11:0] a, input logic [31:0] nv);
    int idx;
    idx = int'(a[4:0]);
    if (a[11:8] == 4'hB && a[6:5] == 2'b00) begin
      if (idx == 0 || idx == 2 || (idx >= 3 && idx < 3 + N_HPM)) begin
        if (a[7]) cnt[idx] = (64'(nv) << 32) | (cnt[idx] & 64'h0000_0000_FFFF_FFFF);
        else      cnt[idx] = (cnt[idx] & 64'hFFFF_FFFF_0000_0000) | 64'(nv);
        skip[idx] = 1'b1;
      end
    end else begin
      case (a)
        12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
        12'h304: m_mie_r = nv & 32'h0000_0888;
        12'h305: m_mtvec = nv[1] ? (nv & ~32'h3) : nv;
        12'h320: m_inh = nv & 32'h0000_003D;
        12'h340: m_mscratch = nv;
        12'h341: m_mepc = nv & ~32'h3;
        12'h342: m_mcause = nv;
        12'h343: m_mtval = nv;
        default: ;
      endcase
    end
  endfunction

  function automatic logic [31:0] m_vector();
    logic [31:0] base;
    base = m_mtvec & ~32'h3;
    if (m_mtvec[1:0] == 2'b01 && trap_cause[31]) return base + 32'(trap_cause[4:0]) * 4;
    return base;
  endfunction

  function automatic bit m_irq();
    logic [31:0] pend;
    pend = (32'(irq_ext) << 11) | (32'(irq_timer) << 7) | (32'(irq_soft) << 3);
    return m_mie && ((pend & m_mie_r) != 0);
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  function automatic void model_step();
    logic [31:0] old, opv, nv, inh_pre;
    bit ok, wr, ill;
    m_read(csr_addr, old, ok);
    wr  = (csr_func3[1:0] == 2'b01) || (csr_imm != 5'd0);
    ill = !ok || (csr_func3[1:0] == 2'b00) || (wr && csr_addr[11:10] == 2'b11);
    exp_done  = csr_req;
    exp_ill   = csr_req && ill;
    exp_rdata = (csr_req && !ill) ? old : 32'h0;
    opv = csr_func3[2] ? {27'd0, csr_imm} : csr_rs1_data;
    case (csr_func3[1:0])
      2'b01:   nv = opv;
      2'b10:   nv = old | opv;
      default: nv = old & ~opv;
    endcase
    inh_pre = m_inh;
    foreach (skip[i]) skip[i] = 1'b0;
    if (trap_valid) begin
      m_mepc = trap_pc & ~32'h3; m_mcause = trap_cause; m_mtval = trap_tval;
      m_mpie = m_mie; m_mie = 1'b0;
    end else if (mret) begin
      m_mie = m_mpie; m_mpie = 1'b1;
    end else if (csr_req && !ill && wr) begin
      m_write(csr_addr, nv);
    end
    if (!skip[0] && !inh_pre[0]) cnt[0]++;
    if (!skip[2] && !inh_pre[2] && instr_retired) cnt[2]++;
    for (int k = 0; k < N_HPM; k++)
      if (!skip[3+k] && !inh_pre[3+k] && hpm_event[k]) cnt[3+k]++;
  endfunction

  // One clock: combinational checks before the edge, registered checks after.
  task automatic step();
    #1;
    chk("trap_vector", trap_vector, m_vector());
    chk("mret_pc", mret_pc, m_mepc);
    chk("irq_pending", 32'(irq_pending), 32'(m_irq()));
    model_step();
    @(posedge clk);
    #1;
    last_done = csr_done; last_rdata = csr_rdata; last_ill = csr_illegal;
    chk("csr_done", 32'(csr_done), 32'(exp_done));
    if (exp_done) begin
      chk($sformatf("csr_rdata@%h", csr_addr), csr_rdata, exp_rdata);
      chk($sformatf("csr_illegal@%h", csr_addr), 32'(csr_illegal), 32'(exp_ill));
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    csr_req = 0; csr_func3 = 3'b010; csr_addr = 12'h340; csr_rs1_data = 0; csr_imm = 0;
    instr_retired = 0; hpm_event = '0; trap_valid = 0; trap_cause = 0; trap_pc = 0;
    trap_tval = 0; mret = 0;
  endtask

  task automatic csr(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] d,
                     input logic [4:0] im);
    csr_req = 1; csr_func3 = f3; csr_addr = a; csr_rs1_data = d; csr_imm = im;
    step();
    csr_req = 0;
  endtask

  task automatic csr_read(input logic [11:0] a);
    csr(3'b010, a, 32'h0, 5'd0);
  endtask

  logic [11:0] pool [36] = '{
    12'h300, 12'h301, 12'h304, 12'h305, 12'h320, 12'h340, 12'h341, 12'h342, 12'h343,
    12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hB03, 12'hB83, 12'hB04, 12'hB05,
    12'hB85, 12'hB06, 12'hB01, 12'hC00, 12'hC80, 12'hC01, 12'hC81, 12'hC02, 12'hC82,
    12'hC03, 12'hC83, 12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h7C0, 12'h000, 12'h306};

  initial begin
    idle_inputs();
    irq_ext = 0; irq_timer = 0; irq_soft = 0;
    rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    m_reset();
    #1;
    chk("reset csr_done", 32'(csr_done), 32'h0);
    chk("reset csr_rdata", csr_rdata, 32'h0);
    chk("reset trap_vector", trap_vector, 32'h0);
    chk("reset irq_pending", 32'(irq_pending), 32'h0);

    // mscratch RW / RS / RCI sequence
    csr(3'b001, 12'h340, 32'hDEADBEEF, 5'd1);
    chk("rw mscratch old", last_rdata, 32'h0);
    csr(3'b010, 12'h340, 32'h0000_00F0, 5'd2);
    chk("rs mscratch old", last_rdata, 32'hDEADBEEF);
    csr(3'b111, 12'h340, 32'h0, 5'h0F);
    chk("rci mscratch old", last_rdata, 32'hDEADBEFF);
    csr_read(12'h340);
    chk("mscratch final", last_rdata, 32'hDEADBEF0);

    // illegal accesses
    csr(3'b001, 12'hF11, 32'h1, 5'd1);
    chk("write mvendorid illegal", 32'(last_ill), 32'h1);
    csr_read(12'h7C0);
    chk("unknown addr illegal", 32'(last_ill), 32'h1);
    csr(3'b110, 12'hF11, 32'h0, 5'd0);
    chk("rsi0 mvendorid legal", 32'(last_ill), 32'h0);
    csr(3'b000, 12'h340, 32'h1, 5'd1);
    chk("funct3 000 illegal", 32'(last_ill), 32'h1);

    // vectored trap and mret
    irq_timer = 1;
    csr(3'b001, 12'h305, 32'h101, 5'd1);
    csr(3'b001, 12'h300, 32'h8, 5'd1);
    csr(3'b001, 12'h304, 32'h80, 5'd1);
    #1 chk("irq_pending set", 32'(irq_pending), 32'h1);
    trap_valid = 1; trap_cause = 32'h8000_0007; trap_pc = 32'h1234; trap_tval = 32'h55;
    #1 chk("vectored trap_vector", trap_vector, 32'h11C);
    step();
    idle_inputs();
    #1 chk("irq_pending after trap", 32'(irq_pending), 32'h0);
    csr_read(12'h300);
    chk("mstatus after trap", last_rdata, 32'h1880);
    mret = 1; step(); mret = 0;
    csr_read(12'h300);
    chk("mstatus after mret", last_rdata, 32'h1888);
    irq_timer = 0;

    // mcycle carry and inhibit
    csr(3'b001, 12'hB80, 32'h5, 5'd1);
    csr(3'b001, 12'hB00, 32'hFFFF_FFFF, 5'd1);
    step();
    csr_read(12'hB00);
    chk("mcycle lo wrapped", last_rdata, 32'h0);
    csr_read(12'hB80);
    chk("mcycleh carried", last_rdata, 32'h6);
    csr(3'b001, 12'h320, 32'h1, 5'd1);
    csr_read(12'hB00);
    chk("mcycle at inhibit", last_rdata, 32'h3);
    csr_read(12'hB00);
    chk("mcycle frozen", last_rdata, 32'h3);
    csr(3'b001, 12'h320, 32'h0, 5'd1);

    // trap beats a same-cycle mepc write
    trap_valid = 1; trap_cause = 32'h2; trap_pc = 32'h203;
    #1 chk("non-irq trap_vector", trap_vector, 32'h100);
    csr(3'b001, 12'h341, 32'h40, 5'd1);
    idle_inputs();
    chk("discarded csr done", 32'(last_done), 32'h1);
    chk("discarded csr rdata", last_rdata, 32'h1234);
    #1 chk("mepc from trap", mret_pc, 32'h200);

    // randomized run
    for (int n = 0; n < 3000; n++) begin
      csr_req       = ($urandom_range(1) == 1);
      csr_func3     = 3'($urandom_range(7));
      csr_addr      = pool[$urandom_range(35)];
      csr_rs1_data  = $urandom;
      csr_imm       = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom_range(31));
      instr_retired = ($urandom_range(1) == 1);
      hpm_event     = 3'($urandom_range(7));
      trap_valid    = ($urandom_range(15) == 0);
      trap_cause    = {1'($urandom_range(1)), 26'd0, 5'($urandom_range(31))};
      trap_pc       = $urandom;
      trap_tval     = $urandom;
      mret          = ($urandom_range(15) == 0);
      irq_ext       = 1'($urandom_range(1));
      irq_timer     = 1'($urandom_range(1));
      irq_soft      = 1'($urandom_range(1));
      step();
    end
    idle_inputs();

    // reset while a request is in flight
    csr_req = 1; csr_func3 = 3'b001; csr_addr = 12'h340; csr_rs1_data = 32'h1; csr_imm = 5'd1;
    #2 rst_n = 0;
    @(posedge clk);
    #1 chk("done under reset", 32'(csr_done), 32'h0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1;
    m_reset();
    step();
    csr_read(12'h340);
    chk("mscratch after reset", last_rdata, 32'h0);
    csr_read(12'h305);
    chk("mtvec after reset", last_rdata, 32'h0);
    csr_read(12'h300);
    chk("mstatus after reset", last_rdata, 32'h1800);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
